nrs_top_tx: RTL

NRS_TOP_TX -- requirements
Module: nrs_top_tx

---
 rtl/nrs_top_tx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/nrs_top_tx.sv
// NB-IoT narrowband reference signal generator: per-symbol Gold-sequence seeding,
// warm-up, and QPSK emission of two REs per NRS symbol over one radio frame.
module nrs_top_tx #(
    parameter int NRS_WIDTH_R_I = 16,
    parameter int NUM_SHIFTS    = 1600,
    parameter int NRS_AMP       = 23170
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     new_frame,
    input  logic [8:0]               N_cell_ID,
    input  logic                     nrs_ready,
    output logic                     nrs_valid,
    output logic [NRS_WIDTH_R_I-1:0] nrs_r,
    output logic [NRS_WIDTH_R_I-1:0] nrs_i,
    output logic [3:0]               nrs_k,
    output logic [4:0]               nrs_ns,
    output logic [2:0]               nrs_l,
    output logic                     frame_done,
    output logic                     busy
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SEED = 3'd1;
    localparam logic [2:0] WARM = 3'd2;
    localparam logic [2:0] EMIT = 3'd3;
    localparam logic [2:0] NEXT = 3'd4;

    localparam int CNT_W = (NUM_SHIFTS > 1) ? $clog2(NUM_SHIFTS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SHIFTS - 1);

    localparam logic [NRS_WIDTH_R_I-1:0] AMP_POS = NRS_WIDTH_R_I'(NRS_AMP);
    localparam logic [NRS_WIDTH_R_I-1:0] AMP_NEG = NRS_WIDTH_R_I'(-NRS_AMP);

    logic [2:0]               state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [8:0]               id_reg;
    logic [4:0]               ns_reg;
    logic [2:0]               l_reg;
    logic                     m_reg;
    logic [30:0]              x1_reg;
    logic [30:0]              x2_reg;
    logic                     valid_reg;
    logic [NRS_WIDTH_R_I-1:0] r_reg;
    logic [NRS_WIDTH_R_I-1:0] i_reg;
    logic [3:0]               k_reg;
    logic                     done_reg;
    logic                     busy_reg;

    logic [7:0]  sym_term;
    logic [9:0]  id_term;
    logic [17:0] cinit_hi;
    logic [27:0] cinit;
    logic [30:0] x1_step;
    logic [30:0] x2_step;
    logic [1:0]  c_warm;
    logic [1:0]  c_hold;
    logic [2:0]  id_mod6;
    logic [3:0]  k_sum;
    logic [3:0]  k_base;
    logic        accept;
    logic        last_sym;
    logic        final_accept;

    function automatic logic [NRS_WIDTH_R_I-1:0] qpsk(input logic b);
        return b ? AMP_NEG : AMP_POS;
    endfunction

    // cinit = 1024*a*b + b with b = 2*ID+1 < 1024, so the low term fits the zero bits
    always_comb begin
        sym_term = 8'd7 * (8'(ns_reg) + 8'd1) + 8'(l_reg) + 8'd1;
        id_term  = {id_reg, 1'b1};
        cinit_hi = 18'(sym_term) * 18'(id_term);
        cinit    = {cinit_hi, id_term};
    end

    // Register bit j holds x(n+j); one step shifts down and appends x(n+31)
    always_comb begin
        x1_step = {x1_reg[3] ^ x1_reg[0], x1_reg[30:1]};
        x2_step = {x2_reg[3] ^ x2_reg[2] ^ x2_reg[1] ^ x2_reg[0], x2_reg[30:1]};
        c_warm  = x1_step[1:0] ^ x2_step[1:0];
        c_hold  = x1_reg[3:2] ^ x2_reg[3:2];
    end

    always_comb begin
        id_mod6 = 3'(id_reg % 9'd6);
        k_sum   = {1'b0, id_mod6} + ((l_reg == 3'd6) ? 4'd3 : 4'd0);
        k_base  = (k_sum >= 4'd6) ? (k_sum - 4'd6) : k_sum;
    end

    always_comb begin
        accept       = valid_reg & nrs_ready;
        last_sym     = (ns_reg == 5'd19) && (l_reg == 3'd6);
        final_accept = (state_reg == EMIT) && accept && m_reg && last_sym;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            id_reg    <= '0;
            ns_reg    <= '0;
            l_reg     <= '0;
            m_reg     <= 1'b0;
            x1_reg    <= '0;
            x2_reg    <= '0;
            valid_reg <= 1'b0;
            r_reg     <= '0;
            i_reg     <= '0;
            k_reg     <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (new_frame) begin
                // A new frame always wins; completing a frame in the same cycle still reports it
                id_reg    <= N_cell_ID;
                ns_reg    <= 5'd0;
                l_reg     <= 3'd5;
                m_reg     <= 1'b0;
                cnt_reg   <= '0;
                valid_reg <= 1'b0;
                busy_reg  <= 1'b1;
                done_reg  <= final_accept;
                state_reg <= SEED;
            end else begin
                case (state_reg)
                    IDLE: begin
                        valid_reg <= 1'b0;
                    end
                    SEED: begin
                        x1_reg    <= 31'd1;
                        x2_reg    <= {3'b000, cinit};
                        cnt_reg   <= '0;
                        state_reg <= WARM;
                    end
                    WARM: begin
                        x1_reg <= x1_step;
                        x2_reg <= x2_step;
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= EMIT;
                            valid_reg <= 1'b1;
                            m_reg     <= 1'b0;
                            r_reg     <= qpsk(c_warm[0]);
                            i_reg     <= qpsk(c_warm[1]);
                            k_reg     <= k_base;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    EMIT: begin
                        // c(2) and c(3) are already in the registers; no further shifting needed
                        if (accept) begin
                            if (!m_reg) begin
                                m_reg <= 1'b1;
                                r_reg <= qpsk(c_hold[0]);
                                i_reg <= qpsk(c_hold[1]);
                                k_reg <= k_base + 4'd6;
                            end else begin
                                valid_reg <= 1'b0;
                                done_reg  <= last_sym;
                                state_reg <= NEXT;
                            end
                        end
                    end
                    NEXT: begin
                        if (last_sym) begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= SEED;
                            if (l_reg == 3'd5) begin
                                l_reg <= 3'd6;
                            end else begin
                                l_reg  <= 3'd5;
                                ns_reg <= (ns_reg == 5'd9) ? 5'd12 : ns_reg + 5'd1;
                            end
                        end
                    end
                    default: begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign nrs_valid  = valid_reg;
    assign nrs_r      = r_reg;
    assign nrs_i      = i_reg;
    assign nrs_k      = k_reg;
    assign nrs_ns     = ns_reg;
    assign nrs_l      = l_reg;
    assign frame_done = done_reg;
    assign busy       = busy_reg;

endmodule
